call_stack_ctrl: RTL

Return-address stack controller for the MIPS core. It sequences the hardware call stack used by JAL (push of the return address) and JS (pop into PC). It also owns the single data-memory port, multiplexing ordinary lw/sw traffic with stack pushes and pops. It sits between the decoded control signals and data memory, and stalls the PC for the extra cycle a pop needs.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/call_stack_ctrl_stack_ptr.sv | 39 +++
 rtl/call_stack_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: call-stack FSM states, width defaults, stack
// placement and the decode encodings that identify JAL/JS.
package mips_pkg;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_POP_WAIT = 1'b1
  } cs_state_t;

  localparam int              DATA_W_DEF     = 32;
  localparam int              ADDR_W_DEF     = 10;
  localparam int              DEPTH_DEF      = 32;
  localparam logic [9:0]      STACK_BASE_DEF = 10'h3C0;

  // JAL is MemtoReg==LINK with Jump==JAL; JS is Jump==JS.
  localparam logic [1:0]      JUMP_JAL       = 2'b01;
  localparam logic [1:0]      JUMP_JS        = 2'b10;
  localparam logic [1:0]      MEMTOREG_LINK  = 2'b10;

endpackage

// File: rtl/call_stack_ctrl_stack_ptr.sv
// Saturating up/down entry counter for the return-address stack.
module stack_ptr
  import mips_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int SP_W  = $clog2(DEPTH + 1)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_inc,
  input  logic            i_dec,
  output logic [SP_W-1:0] o_count,
  output logic            o_full,
  output logic            o_empty
);

  logic [SP_W-1:0] r_count;
  logic            w_full;
  logic            w_empty;

  assign w_full  = (r_count == SP_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // Simultaneous inc and dec cancel; both ends hold rather than wrap.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_inc && !i_dec && !w_full) begin
      r_count <= r_count + SP_W'(1);
    end else if (i_dec && !i_inc && !w_empty) begin
      r_count <= r_count - SP_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/call_stack_ctrl.sv
// Return-address stack controller: sequences JAL pushes / JS pops and
// multiplexes them with ordinary lw/sw traffic onto the single data-memory port.
module call_stack_ctrl
  import mips_pkg::*;
#(
  parameter int               DATA_W     = DATA_W_DEF,
  parameter int               ADDR_W     = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] STACK_BASE = STACK_BASE_DEF,
  parameter int               DEPTH      = DEPTH_DEF,
  parameter int               SP_W       = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_push_req,
  input  logic              i_pop_req,
  input  logic              i_halt,
  input  logic [DATA_W-1:0] i_ret_addr,
  input  logic              i_ls_read,
  input  logic              i_ls_write,
  input  logic [ADDR_W-1:0] i_ls_addr,
  input  logic [DATA_W-1:0] i_ls_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  output logic              o_mem_re,
  output logic              o_stall,
  output logic              o_pop_valid,
  output logic [DATA_W-1:0] o_pop_target,
  output logic [SP_W-1:0]   o_sp,
  output logic              o_overflow,
  output logic              o_underflow
);

  cs_state_t         r_state;
  logic              r_empty_pop;
  logic              r_pop_valid;
  logic [DATA_W-1:0] r_pop_target;
  logic              r_overflow;
  logic              r_underflow;

  logic [SP_W-1:0]   w_sp;
  logic              w_full;
  logic              w_empty;
  logic              w_accept;
  logic              w_do_push;
  logic              w_do_dec;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              w_mem_we;
  logic              w_mem_re;
  logic              w_stall;

  // New requests are only looked at in IDLE, out of reset and not halted.
  assign w_accept  = !i_reset && (r_state == ST_IDLE) && !i_halt;
  assign w_do_push = w_accept && i_push_req && !i_pop_req && !w_full;
  assign w_do_dec  = (r_state == ST_POP_WAIT) && !r_empty_pop;

  stack_ptr #(
    .DEPTH (DEPTH),
    .SP_W  (SP_W)
  ) u_stack_ptr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (w_do_push),
    .i_dec   (w_do_dec),
    .o_count (w_sp),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Port mux: a stack request owns the port even when it performs no access,
  // which is how the JAL-decoded ls_write gets absorbed.
  always_comb begin
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_mem_we    = 1'b0;
    w_mem_re    = 1'b0;
    w_stall     = 1'b0;
    if (w_accept) begin
      if (i_pop_req) begin
        w_stall = 1'b1;
        if (!w_empty) begin
          w_mem_re   = 1'b1;
          w_mem_addr = STACK_BASE + ADDR_W'(w_sp) - ADDR_W'(1);
        end
      end else if (i_push_req) begin
        if (!w_full) begin
          w_mem_we    = 1'b1;
          w_mem_addr  = STACK_BASE + ADDR_W'(w_sp);
          w_mem_wdata = i_ret_addr;
        end
      end else begin
        w_mem_addr  = i_ls_addr;
        w_mem_wdata = i_ls_wdata;
        w_mem_we    = i_ls_write;
        w_mem_re    = i_ls_read;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_empty_pop  <= 1'b0;
      r_pop_valid  <= 1'b0;
      r_pop_target <= '0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_pop_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!i_halt) begin
            if (i_pop_req) begin
              r_state     <= ST_POP_WAIT;
              r_empty_pop <= w_empty;
              if (w_empty) r_underflow <= 1'b1;
            end
            // Push while full, or push+pop together (illegal decode).
            if (i_push_req && (i_pop_req || w_full)) r_overflow <= 1'b1;
          end
        end
        ST_POP_WAIT: begin
          r_state      <= ST_IDLE;
          r_pop_valid  <= 1'b1;
          r_pop_target <= r_empty_pop ? '0 : i_mem_rdata;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_mem_addr   = w_mem_addr;
  assign o_mem_wdata  = w_mem_wdata;
  assign o_mem_we     = w_mem_we;
  assign o_mem_re     = w_mem_re;
  assign o_stall      = w_stall;
  assign o_pop_valid  = r_pop_valid;
  assign o_pop_target = r_pop_target;
  assign o_sp         = w_sp;
  assign o_overflow   = r_overflow;
  assign o_underflow  = r_underflow;

endmodule
